// File: rtl/fpu_mul_sequencer_if.sv
// Operand/result handshake and multiplier-side bundle of the FP multiply sequencer.
interface fpu_mul_sequencer_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_enable;
    logic [31:0] mul_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [3:0]  out_flags;
    logic [15:0] op_count;

    modport slave (
        input  flush, in_valid, in_a, in_b, mul_res, out_ready,
        output in_ready, mul_a, mul_b, mul_enable, out_valid, out_res, out_flags, op_count
    );

    modport master (
        output flush, in_valid, in_a, in_b, mul_res, out_ready,
        input  in_ready, mul_a, mul_b, mul_enable, out_valid, out_res, out_flags, op_count
    );
endinterface

// File: rtl/fpu_mul_sequencer.sv
// Drives a fixed-latency sequential FP multiplier: one operand pair in, wait, capture and
// classify the product, hold it until the consumer takes it.
module fpu_mul_sequencer #(
    parameter int unsigned MUL_LATENCY = 34
) (
    input  logic               clk,
    input  logic               reset,
    fpu_mul_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] CNT_LOAD = 8'(MUL_LATENCY - 1);

    // {nan, inf, zero, neg} of an IEEE-754 single
    function automatic logic [3:0] classify(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        classify = {(e == 8'hFF) && (m != 23'd0),
                    (e == 8'hFF) && (m == 23'd0),
                    (e == 8'h00) && (m == 23'd0),
                    v[31]};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;
    logic        valid_q, valid_d;
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        res_d      = res_q;
        flags_d    = flags_q;
        valid_d    = valid_q;
        op_count_d = op_count_q;

        // flush outranks both the input handshake and the result handshake
        if (bus.flush) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        mul_a_d = bus.in_a;
                        mul_b_d = bus.in_b;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        res_d   = bus.mul_res;
                        flags_d = classify(bus.mul_res);
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_DONE: begin
                    // result data is left in place after consumption
                    if (bus.out_ready) begin
                        valid_d    = 1'b0;
                        op_count_d = op_count_q + 16'd1;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            res_q      <= 32'd0;
            flags_q    <= 4'd0;
            valid_q    <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            valid_q    <= valid_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.mul_enable = (state_q == S_LOAD);
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_res    = res_q;
    assign bus.out_flags  = flags_q;
    assign bus.op_count   = op_count_q;

    a_valid_ready_excl: assert property (@(posedge clk) disable iff (!reset)
        !(bus.out_valid && bus.in_ready));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset)
        (state_q == S_WAIT) |-> (cnt_q <= CNT_LOAD));
    a_valid_done: assert property (@(posedge clk) disable iff (!reset)
        bus.out_valid |-> (state_q == S_DONE));
endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// Scoreboard bench for fpu_mul_sequencer with a fixed-latency multiplier model.
module tb_fpu_mul_sequencer;
    localparam int unsigned LAT = 34;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fpu_mul_sequencer_if bus ();
    fpu_mul_sequencer_if bus1 ();

    fpu_mul_sequencer #(.MUL_LATENCY(LAT)) dut  (.clk(clk), .reset(reset), .bus(bus));
    fpu_mul_sequencer #(.MUL_LATENCY(1))   dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mulq[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [3:0] ref_flags(input logic [31:0] v);
        int unsigned e, m;
        bit nan, inf, zero;
        e    = v[30:23];
        m    = v[22:0];
        nan  = (e == 255) && (m != 0);
        inf  = (e == 255) && (m == 0);
        zero = (e == 0) && (m == 0);
        return {nan, inf, zero, v[31]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // multiplier model: product becomes valid LAT cycles after the enable cycle
    logic [31:0] plan = 32'd0;
    int          mk = 0;
    always @(negedge clk) begin
        if (bus.mul_enable) begin
            if (mulq.size() > 0) plan = mulq.pop_front();
            bus.mul_res = plan ^ 32'hDEAD_BEEF;
            mk = LAT;
        end else if (mk > 0) begin
            mk--;
            if (mk == 0) bus.mul_res = plan;
        end
    end

    // monitor
    bit          hs_prev = 0, counting = 0, prev_valid = 0, prev_consume = 0;
    int          lat = 0;
    logic [31:0] last_a = 0, last_b = 0, res_model = 0;
    logic [3:0]  flags_model = 0;
    logic [15:0] cnt_model = 0;
    always @(negedge clk) begin
        if (!reset) begin
            hs_prev = 0; counting = 0; prev_valid = 0; prev_consume = 0; lat = 0;
            last_a = 0; last_b = 0; res_model = 0; flags_model = 0; cnt_model = 0;
        end else begin
            exp_t e;
            if (counting) lat++;
            chk("mul_enable", bus.mul_enable, hs_prev);
            chk("mul_a_stable", bus.mul_a, last_a);
            chk("mul_b_stable", bus.mul_b, last_b);
            chk("op_count", bus.op_count, cnt_model);
            chk("valid_ready_excl", bus.out_valid & bus.in_ready, 0);
            if (bus.out_valid && !prev_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out_valid", bus.out_valid, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_res", bus.out_res, e.res);
                    chk("out_flags", bus.out_flags, e.flags);
                    chk("latency_edges", lat, LAT + 2);
                    res_model   = e.res;
                    flags_model = e.flags;
                end
                counting = 0;
            end else begin
                chk("out_res_hold", bus.out_res, res_model);
                chk("out_flags_hold", bus.out_flags, flags_model);
            end
            if (prev_consume) chk("idle_after_consume", {bus.out_valid, bus.in_ready}, 2'b01);
            hs_prev = bus.in_valid && bus.in_ready && !bus.flush;
            if (hs_prev) begin
                last_a = bus.in_a; last_b = bus.in_b; counting = 1; lat = 0;
            end
            prev_consume = bus.out_valid && bus.out_ready && !bus.flush;
            if (prev_consume) cnt_model++;
            if (bus.flush) counting = 0;
            prev_valid = bus.out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input bit expect_out);
        int n;
        exp_t e;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        mulq.push_back(r);
        if (expect_out) begin
            e.res = r;
            e.flags = ref_flags(r);
            expq.push_back(e);
        end
        n = 0;
        while (!bus.in_ready && n < 200) begin tick(); n++; end
        chk("issue_wait", n >= 200, 0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish(input int bp, input bit overlap);
        int n;
        n = 0;
        while (!bus.out_valid && n < 300) begin tick(); n++; end
        chk("done_wait", n >= 300, 0);
        repeat (bp) tick();
        bus.out_ready = 1'b1;
        if (overlap) bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, r;
        int sel;
        bus.flush = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
        bus.mul_res = 0; bus.out_ready = 0;
        bus1.flush = 0; bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0;
        bus1.mul_res = 0; bus1.out_ready = 0;

        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_out_res", bus.out_res, 0);
        chk("rst_op_count", bus.op_count, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_in_ready", bus.in_ready, 1);

        // directed vectors
        issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1); finish(0, 0);
        chk("op_count_after_first", bus.op_count, 1);
        issue(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 1); finish(1, 1);
        issue(32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000, 1); finish(2, 0);
        issue(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1); finish(0, 1);
        issue(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1); finish(20, 0);
        chk("bp_release_idle", {bus.out_valid, bus.in_ready}, 2'b01);

        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; r = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) r = {r[31], 8'hFF, 23'd0};
            else if (sel == 1) r = {r[31], 8'hFF, r[22:1], 1'b1};
            else if (sel == 2) r = {r[31], 31'd0};
            issue(a, b, r, 1);
            finish($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // flush in WAIT: the result must never appear
        issue(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0);
        repeat (5) tick();
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        chk("flush_wait_idle", {bus.out_valid, bus.in_ready}, 2'b01);
        repeat (LAT + 10) tick();

        // flush in DONE beats out_ready
        issue(32'h4444_4444, 32'h5555_5555, 32'h4080_0000, 1);
        while (!bus.out_valid) tick();
        tick();
        bus.flush = 1'b1; bus.out_ready = 1'b1; tick();
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        chk("flush_done_idle", {bus.out_valid, bus.in_ready}, 2'b01);

        // flush together with in_valid in IDLE: no handshake
        bus.in_a = 32'hAAAA_AAAA; bus.in_valid = 1'b1; bus.flush = 1'b1; tick();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_idle_no_load", bus.mul_enable, 0);
        chk("flush_idle_in_ready", bus.in_ready, 1);

        // asynchronous reset mid-WAIT abandons the operation
        issue(32'h6666_6666, 32'h7777_7777, 32'h0BAD_0BAD, 0);
        repeat (24) tick();
        #1 reset = 1'b0;
        #1;
        chk("arst_mul_a", bus.mul_a, 0);
        chk("arst_mul_b", bus.mul_b, 0);
        chk("arst_mul_enable", bus.mul_enable, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_res", bus.out_res, 0);
        chk("arst_out_flags", bus.out_flags, 0);
        chk("arst_op_count", bus.op_count, 0);
        @(posedge clk); #2 reset = 1'b1;
        repeat (LAT + 10) tick();
        issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1); finish(0, 0);
        chk("op_count_after_reset_op", bus.op_count, 1);

        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        cnt_model = 16'hFFFF;
        tick();
        release dut.op_count_q;
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1); finish(0, 0);
        chk("op_count_wrap", bus.op_count, 16'h0000);

        // MUL_LATENCY=1 build: out_valid on the third edge counting the handshake edge
        bus1.mul_res = 32'hFFFF_0000;
        bus1.in_a = 32'h4000_0000; bus1.in_b = 32'h4000_0000; bus1.in_valid = 1'b1;
        chk("l1_in_ready", bus1.in_ready, 1);
        tick();
        bus1.in_valid = 1'b0;
        chk("l1_enable", bus1.mul_enable, 1);
        tick();
        chk("l1_no_early_valid", bus1.out_valid, 0);
        bus1.mul_res = 32'h4080_0000;
        tick();
        chk("l1_out_valid", bus1.out_valid, 1);
        chk("l1_out_res", bus1.out_res, 32'h4080_0000);
        chk("l1_out_flags", bus1.out_flags, ref_flags(32'h4080_0000));
        bus1.out_ready = 1'b1; tick(); bus1.out_ready = 1'b0;
        chk("l1_op_count", bus1.op_count, 1);
        chk("l1_idle", {bus1.out_valid, bus1.in_ready}, 2'b01);

        repeat (3) tick();
        chk("scoreboard_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
